// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external ALU between two requesters. A request is accepted in
//   IDLE, executed on the ALU for exactly one cycle (EXEC), and the registered
//   result is presented to its owner in RESP until the owner consumes it.
//   When both requesters are valid, a round-robin pointer gives the grant to
//   the one that was not served last.
//
// Ports
//   clk, rst_n                rising-edge clock, synchronous active-low reset
//   reqN_valid/ready          request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_op   operands and 4-bit ALU control code
//   rspN_valid/ready          response handshake, N = 0,1
//   rsp_data/zero/err         shared result, zero flag, illegal-op flag
//   alu_a, alu_b, alu_ctrl    operands/control to the shared ALU
//   alu_out, alu_zero         result/zero flag from the shared ALU
//   alu_en                    ALU activity enable
//   state_dbg                 current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Handshake rule: a transfer happens on a rising edge where valid && ready
// are both high. Valid may rise or fall freely while ready is low; ready
// never depends on anything but state, pointer, reset and the two valids.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             alu_en,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant;   // requester served most recently
  logic             owner;        // requester whose operation is in flight
  logic             grant;        // requester that would be accepted in IDLE
  logic             accept;       // a transfer happens at the next edge
  logic             rsp_done;     // owner consumes the response at the next edge
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             illegal;

  assign illegal   = op_q[3];
  assign state_dbg = state;

  // Round-robin: on contention, pick the requester not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = 4'b0000;
    alu_en     = 1'b0;
    case (state)
      IDLE: begin
        // Ready is held low while reset is asserted so no output is high
        // during reset even if a requester keeps valid up.
        accept     = rst_n && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        // Illegal ops leave the ALU quiet; the response is synthesised.
        if (!illegal) begin
          alu_a    = a_q;
          alu_b    = b_q;
          alu_ctrl = op_q;
          alu_en   = 1'b1;
        end
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        // Only the owner's ready matters; the other one is ignored.
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 4'b0000;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant;
            a_q   <= grant ? req1_a  : req0_a;
            b_q   <= grant ? req1_b  : req0_b;
            op_q  <= grant ? req1_op : req0_op;
          end
        end
        EXEC: begin
          if (illegal) begin
            rsp_data <= '0;
            rsp_zero <= 1'b1;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_done) last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule
